// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and frame timing helper.
// Imported by the transmitter, its FIFO and the receiver-side benches.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE_TX  = 2'd0,
    START_TX = 2'd1,
    DATA_TX  = 2'd2,
    STOP_TX  = 2'd3
  } tx_state_t;

  // Clock cycles in one complete frame: start bit, data bits, stop bit.
  function automatic int frame_clks(input int data_width, input int clks_per_bit);
    return (data_width + 2) * clks_per_bit;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO on a register array with wrap-around pointers.
// dout always presents the oldest word, so a pop consumes what is visible now.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $error("sync_fifo: DEPTH must be a power of two, at least 2");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  // Guarding here keeps the pointers coherent even if a caller misbehaves.
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign full  = (r_count == (AW + 1)'(DEPTH));
  assign empty = (r_count == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: buffers words in a small FIFO and serialises them as
// start / DATA_WIDTH data bits LSB first / stop frames, back to back when queued.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         din,
  input  logic                          din_valid,
  output logic                          din_ready,
  output logic                          serial_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_WIDTH);

  if ((DATA_WIDTH < 5) || (DATA_WIDTH > 9) || (CLKS_PER_BIT < 2)) begin : g_param_check
    $error("uart_tx: DATA_WIDTH must be 5..9 and CLKS_PER_BIT at least 2");
  end

  tx_state_t             r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic                  r_serial;

  logic                  w_push;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_fifo_dout;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_cnt_last;
  logic                  w_idx_last;

  assign w_cnt_last = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign w_idx_last = (r_idx == IDX_W'(DATA_WIDTH - 1));

  // Pop exactly where the FSM loads a new frame: from idle, or at the end of a stop bit.
  assign w_push = din_valid && din_ready;
  assign w_pop  = !w_empty && ((r_state == IDLE_TX) || ((r_state == STOP_TX) && w_cnt_last));

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (din),
    .dout  (w_fifo_dout),
    .count (fifo_count),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE_TX;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_shreg  <= '0;
      r_serial <= 1'b1;
    end else begin
      case (r_state)
        IDLE_TX: begin
          r_serial <= 1'b1;
          if (!w_empty) begin
            r_shreg  <= w_fifo_dout;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_serial <= 1'b0;
            r_state  <= START_TX;
          end
        end
        START_TX: begin
          if (w_cnt_last) begin
            r_cnt    <= '0;
            r_idx    <= '0;
            r_serial <= r_shreg[0];
            r_state  <= DATA_TX;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DATA_TX: begin
          if (w_cnt_last) begin
            r_cnt <= '0;
            if (w_idx_last) begin
              r_serial <= 1'b1;
              r_state  <= STOP_TX;
            end else begin
              r_shreg  <= r_shreg >> 1;
              r_serial <= r_shreg[1];
              r_idx    <= r_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STOP_TX: begin
          if (w_cnt_last) begin
            r_cnt <= '0;
            if (!w_empty) begin
              r_shreg  <= w_fifo_dout;
              r_idx    <= '0;
              r_serial <= 1'b0;
              r_state  <= START_TX;
            end else begin
              r_serial <= 1'b1;
              r_state  <= IDLE_TX;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_cnt    <= '0;
          r_serial <= 1'b1;
          r_state  <= IDLE_TX;
        end
      endcase
    end
  end

  assign din_ready = !w_full;
  assign serial_tx = r_serial;
  assign busy      = (r_state != IDLE_TX) || !w_empty;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed framing checks on two parameter sets plus a
// randomized loopback through a behavioural receiver decoding the line.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int DW8  = 8;
  localparam int CPB8 = 4;
  localparam int DW5  = 5;
  localparam int CPB5 = 2;
  localparam int DEP  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;

  logic [7:0] din8 = '0;
  logic       din_valid8 = 1'b0;
  logic       din_ready8;
  logic       serial8;
  logic       busy8;
  logic [2:0] count8;

  logic [4:0] din5 = '0;
  logic       din_valid5 = 1'b0;
  logic       din_ready5;
  logic       serial5;
  logic       busy5;
  logic [2:0] count5;

  always #5 clk = ~clk;

  uart_tx #(.DATA_WIDTH(DW8), .CLKS_PER_BIT(CPB8), .FIFO_DEPTH(DEP)) dut8 (
    .clk(clk), .reset(reset), .din(din8), .din_valid(din_valid8),
    .din_ready(din_ready8), .serial_tx(serial8), .busy(busy8), .fifo_count(count8)
  );

  uart_tx #(.DATA_WIDTH(DW5), .CLKS_PER_BIT(CPB5), .FIFO_DEPTH(DEP)) dut5 (
    .clk(clk), .reset(reset), .din(din5), .din_valid(din_valid5),
    .din_ready(din_ready5), .serial_tx(serial5), .busy(busy5), .fifo_count(count5)
  );

  int n_vec = 0;
  int n_err = 0;

  logic       rx_en = 1'b0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int         rx_stop_err = 0;

  int acc;
  int guard;
  int lows;
  int timeouts;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Line level t cycles after the start edge of a frame carrying w.
  function automatic logic exp_bit(input logic [31:0] w, input int dw, input int cpb, input int t);
    int slot;
    slot = t / cpb;
    if (slot == 0) return 1'b0;
    else if (slot <= dw) return w[slot-1];
    else return 1'b1;
  endfunction

  // Behavioural receiver on the 8-bit instance: samples each bit mid-cell.
  initial begin
    logic [7:0] w;
    forever begin
      @(negedge clk);
      if (rx_en && serial8 === 1'b0) begin
        repeat (CPB8 / 2) @(negedge clk);
        w = '0;
        for (int b = 0; b < DW8; b++) begin
          repeat (CPB8) @(negedge clk);
          w[b] = serial8;
        end
        repeat (CPB8) @(negedge clk);
        if (serial8 !== 1'b1) rx_stop_err++;
        rx_q.push_back(w);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_serial8", 32'(serial8), 32'd1);
    chk("rst_ready8",  32'(din_ready8), 32'd1);
    chk("rst_busy8",   32'(busy8), 32'd0);
    chk("rst_count8",  32'(count8), 32'd0);
    chk("rst_serial5", 32'(serial5), 32'd1);
    chk("rst_busy5",   32'(busy5), 32'd0);
    chk("rst_count5",  32'(count5), 32'd0);

    // Single word 0xA5: buffered after accept edge, line falls one edge later
    din8 = 8'hA5;
    din_valid8 = 1'b1;
    tick();
    din_valid8 = 1'b0;
    chk("a5_count_after_accept", 32'(count8), 32'd1);
    chk("a5_busy_after_accept", 32'(busy8), 32'd1);
    chk("a5_line_still_idle", 32'(serial8), 32'd1);
    tick();
    for (int k = 0; k < frame_clks(DW8, CPB8); k++) begin
      chk("a5_line", 32'(serial8), 32'(exp_bit(32'hA5, DW8, CPB8, k)));
      if (k == frame_clks(DW8, CPB8) - 1) chk("a5_busy_last", 32'(busy8), 32'd1);
      tick();
    end
    chk("a5_busy_end", 32'(busy8), 32'd0);
    chk("a5_line_end", 32'(serial8), 32'd1);

    // Back-to-back 0x00 then 0xFF: no idle cycle between the frames
    din8 = 8'h00;
    din_valid8 = 1'b1;
    tick();
    din8 = 8'hFF;
    tick();
    din_valid8 = 1'b0;
    for (int k = 0; k < 2 * frame_clks(DW8, CPB8); k++) begin
      chk("b2b_line", 32'(serial8),
          32'(exp_bit((k < frame_clks(DW8, CPB8)) ? 32'h00 : 32'hFF, DW8, CPB8,
                      k % frame_clks(DW8, CPB8))));
      tick();
    end
    chk("b2b_busy_end", 32'(busy8), 32'd0);

    // Width/baud corner: 5 data bits, 2 clocks per bit
    din5 = 5'h15;
    din_valid5 = 1'b1;
    tick();
    din_valid5 = 1'b0;
    chk("w5_count_after_accept", 32'(count5), 32'd1);
    tick();
    for (int k = 0; k < frame_clks(DW5, CPB5); k++) begin
      chk("w5_line", 32'(serial5), 32'(exp_bit(32'h15, DW5, CPB5, k)));
      tick();
    end
    chk("w5_busy_end", 32'(busy5), 32'd0);

    // Backpressure: continuous valid with 0x11, 0x22, ...
    rx_q.delete();
    exp_q.delete();
    rx_stop_err = 0;
    rx_en = 1'b1;
    acc = 0;
    din8 = 8'h11;
    din_valid8 = 1'b1;
    for (int c = 0; c < 20 && din_ready8; c++) begin
      exp_q.push_back(din8);
      acc++;
      tick();
      din8 = 8'(8'h11 * (acc + 1));
    end
    chk("bp_accepted_before_stall", 32'(acc), 32'(DEP + 1));
    chk("bp_count_full", 32'(count8), 32'(DEP));
    chk("bp_ready_low", 32'(din_ready8), 32'd0);
    guard = 0;
    while (!din_ready8 && guard < 100) begin
      tick();
      guard++;
    end
    chk("bp_ready_return", 32'(din_ready8), 32'd1);
    chk("bp_ready_return_delay", 32'(guard), 32'(frame_clks(DW8, CPB8) - (DEP - 1)));
    guard = 0;
    while (acc < 8 && guard < 400) begin
      if (din_ready8) begin
        exp_q.push_back(din8);
        acc++;
        tick();
        din8 = 8'(8'h11 * (acc + 1));
      end else begin
        tick();
      end
      guard++;
    end
    din_valid8 = 1'b0;
    guard = 0;
    while (busy8 && guard < 600) begin
      tick();
      guard++;
    end
    chk("bp_drain", 32'(busy8), 32'd0);
    repeat (6) tick();
    chk("bp_rx_words", 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < rx_q.size()) chk("bp_rx_order", 32'(rx_q[i]), 32'(exp_q[i]));
    end
    chk("bp_stop_bits", 32'(rx_stop_err), 32'd0);

    // Loopback: 256 random words with random gaps through the receiver model
    rx_q.delete();
    exp_q.delete();
    rx_stop_err = 0;
    timeouts = 0;
    for (int i = 0; i < 256; i++) begin
      din8 = 8'($urandom);
      din_valid8 = 1'b1;
      guard = 0;
      while (!din_ready8 && guard < 200) begin
        tick();
        guard++;
      end
      if (guard >= 200) timeouts++;
      exp_q.push_back(din8);
      tick();
      din_valid8 = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    chk("lb_timeouts", 32'(timeouts), 32'd0);
    guard = 0;
    while (busy8 && guard < 2000) begin
      tick();
      guard++;
    end
    chk("lb_drain", 32'(busy8), 32'd0);
    repeat (6) tick();
    rx_en = 1'b0;
    chk("lb_rx_words", 32'(rx_q.size()), 32'd256);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < rx_q.size()) chk("lb_rx_word", 32'(rx_q[i]), 32'(exp_q[i]));
    end
    chk("lb_stop_bits", 32'(rx_stop_err), 32'd0);

    // Reset mid-frame: 0x3C in flight with two words queued
    din8 = 8'h3C;
    din_valid8 = 1'b1;
    tick();
    din8 = 8'h01;
    tick();
    din8 = 8'h02;
    tick();
    din_valid8 = 1'b0;
    chk("rmf_queued", 32'(count8), 32'd2);
    repeat (16) tick();
    chk("rmf_bit3_line", 32'(serial8), 32'(exp_bit(32'h3C, DW8, CPB8, 17)));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rmf_serial", 32'(serial8), 32'd1);
    chk("rmf_count", 32'(count8), 32'd0);
    chk("rmf_busy", 32'(busy8), 32'd0);
    chk("rmf_ready", 32'(din_ready8), 32'd1);
    lows = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (serial8 !== 1'b1) lows++;
    end
    chk("rmf_no_more_frames", 32'(lows), 32'd0);
    chk("rmf_busy_after", 32'(busy8), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
